// File: rtl/rle_fetch_pkg.sv
// Shared types and constants for the RLE flash fetch block.
package rle_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } fetch_state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_BITS    = 8;
  localparam int         CS_HIGH_CLKS  = 2;

endpackage

// File: rtl/rle_word_fifo.sv
// Two-entry 16-bit word FIFO; the head is held in its own register so the
// consumer sees data without any path from its pop request.
module rle_word_fifo
  import rle_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [15:0] din_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [15:0] head_o,
  output logic [1:0]  count_o
);

  logic [15:0] head_q;
  logic [15:0] tail_q;
  logic [1:0]  count_q;
  logic        do_pop;
  logic        do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din_i;
          else                 tail_q <= din_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= din_i;
          end else begin
            head_q <= tail_q;
            tail_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/rle_flash_fetch.sv
// SPI flash read controller feeding the RLE decoder with 16-bit words.
// Define RLE_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module rle_flash_fetch
  import rle_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_next,
  input  logic        stop_data,
  output logic        data_ready,
  output logic [15:0] data,
  input  logic        save_addr,
  input  logic        load_addr,
  input  logic        clear_addr,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int SHIFT_W = 8 + ADDR_W;
  localparam int CNT_W   = 8;

`ifdef RLE_FLASH_FAST_READ_EN
  localparam logic [7:0]   READ_CMD   = CMD_FAST_READ;
  localparam fetch_state_e AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0]   READ_CMD   = CMD_READ;
  localparam fetch_state_e AFTER_ADDR = DATA;
`endif

  fetch_state_e       state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [14:0]        word_q;
  logic               cs_n_q;
  logic               sck_q;
  logic               mosi_q;
  logic [ADDR_W-1:0]  cons_addr_q;
  logic [ADDR_W-1:0]  cons_addr_d;
  logic [ADDR_W-1:0]  saved_addr_q;
  logic [ADDR_W-1:0]  saved_addr_d;
  logic [ADDR_W-1:0]  popped_addr;
  logic               pop;
  logic               flush;
  logic               word_stall;
  logic               word_push;
  logic [15:0]        word_din;
  logic [1:0]         fifo_count;

  assign pop        = read_next && data_ready;
  assign flush      = stop_data || load_addr || clear_addr;
  assign word_din   = {word_q, spi_miso};
  // A new word may only begin once a buffer slot is guaranteed for it.
  assign word_stall = (state_q == DATA) && !sck_q && (cnt_q == '0) &&
                      (fifo_count == 2'd2) && !pop;
  assign word_push  = (state_q == DATA) && !sck_q &&
                      (cnt_q == CNT_W'(15)) && !flush;

  rle_word_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (word_push),
    .din_i   (word_din),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (data),
    .count_o (fifo_count)
  );

  assign data_ready = (fifo_count != 2'd0);
  assign spi_cs_n   = cs_n_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;

  // Save sees the post-pop address; a pop alongside load/clear is dropped.
  always_comb begin
    popped_addr  = cons_addr_q + ADDR_W'(2);
    cons_addr_d  = cons_addr_q;
    saved_addr_d = saved_addr_q;
    if (save_addr) begin
      saved_addr_d = (pop && !load_addr && !clear_addr) ? popped_addr : cons_addr_q;
    end
    if (clear_addr)     cons_addr_d = START_ADDR;
    else if (load_addr) cons_addr_d = saved_addr_q;
    else if (pop)       cons_addr_d = popped_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cons_addr_q  <= START_ADDR;
      saved_addr_q <= START_ADDR;
    end else begin
      cons_addr_q  <= cons_addr_d;
      saved_addr_q <= saved_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q == CNT_W'(CS_HIGH_CLKS)) begin
            state_q <= CMD;
            cnt_q   <= '0;
            cs_n_q  <= 1'b0;
            mosi_q  <= READ_CMD[7];
            shift_q <= {READ_CMD, cons_addr_q} << 1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CMD, ADDR: begin
          if (!sck_q) begin
            sck_q <= 1'b1;
          end else begin
            sck_q <= 1'b0;
            if ((state_q == ADDR) && (cnt_q == CNT_W'(ADDR_W - 1))) begin
              state_q <= AFTER_ADDR;
              cnt_q   <= '0;
              mosi_q  <= 1'b0;
            end else begin
              mosi_q  <= shift_q[SHIFT_W-1];
              shift_q <= shift_q << 1;
              if ((state_q == CMD) && (cnt_q == CNT_W'(7))) begin
                state_q <= ADDR;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        DUMMY: begin
          if (!sck_q) begin
            sck_q <= 1'b1;
          end else begin
            sck_q <= 1'b0;
            if (cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (sck_q) begin
            sck_q <= 1'b0;
          end else if (!word_stall) begin
            sck_q  <= 1'b1;
            word_q <= word_din[14:0];
            cnt_q  <= (cnt_q == CNT_W'(15)) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_flash_fetch.sv
// Directed bench for rle_flash_fetch with a behavioural SPI flash model.
module tb_rle_flash_fetch;

`ifdef RLE_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD  = 8'h0B;
  localparam int         HDR_BITS = 40;
`else
  localparam logic [7:0] EXP_CMD  = 8'h03;
  localparam int         HDR_BITS = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_next = 1'b0;
  logic        stop_data = 1'b0;
  logic        save_addr = 1'b0;
  logic        load_addr = 1'b0;
  logic        clear_addr = 1'b0;
  logic        spi_miso = 1'b0;
  logic        data_ready;
  logic [15:0] data;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_addr = 24'h0;
  logic [23:0] saved_exp = 24'h0;

  // Flash model state
  logic [31:0] rx_sh = '0;
  logic [7:0]  cmd_rx = '0;
  logic [23:0] addr_rx = '0;
  int          rcnt = 0;
  int          dcnt = 0;
  int          hdr_count = 0;
  int          dummy_err = 0;

  rle_flash_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .read_next  (read_next),
    .stop_data  (stop_data),
    .data_ready (data_ready),
    .data       (data),
    .save_addr  (save_addr),
    .load_addr  (load_addr),
    .clear_addr (clear_addr),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] b;
    case (a)
      24'h0:   b = 8'h12;
      24'h1:   b = 8'h34;
      24'h2:   b = 8'h56;
      24'h3:   b = 8'h78;
      default: b = (a[7:0] * 8'd13) ^ 8'h5A;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] flash_word(input logic [23:0] a);
    return {flash_byte(a), flash_byte(a + 24'd1)};
  endfunction

  // Mode-0 flash: samples mosi on sck rise, drives miso after sck fall.
  always @(posedge spi_sck or negedge spi_sck or posedge spi_cs_n) begin
    logic [7:0] b;
    if (spi_cs_n) begin
      rcnt     = 0;
      dcnt     = 0;
      spi_miso = 1'b0;
    end else if (spi_sck) begin
      if (rcnt < 32) rx_sh = {rx_sh[30:0], spi_mosi};
      else if (rcnt < HDR_BITS && spi_mosi) dummy_err++;
      rcnt++;
      if (rcnt == 32) begin
        cmd_rx  = rx_sh[31:24];
        addr_rx = rx_sh[23:0];
        hdr_count++;
      end
    end else if (rcnt >= HDR_BITS) begin
      b        = flash_byte(addr_rx + 24'(dcnt / 8));
      spi_miso = b[7 - (dcnt % 8)];
      dcnt++;
    end
  end

  task automatic wait_ready(input int max_cyc, output bit ok);
    ok = data_ready;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = data_ready;
    end
  endtask

  task automatic wait_hdr(input int prev, input int max_cyc, output bit ok);
    ok = (hdr_count != prev);
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = (hdr_count != prev);
    end
  endtask

  task automatic do_pop;
    read_next = 1'b1;
    @(negedge clk);
    read_next = 1'b0;
    exp_addr  = exp_addr + 24'd2;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
    checks++; if (spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck: got %b expected 0", spi_sck); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b expected 0", spi_mosi); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", data_ready); end
    checks++; if (data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", data); end
    rst = 1'b0;
    exp_addr = 24'h0;
  endtask

  task automatic test_first_words;
    bit ok;
    int cyc;
    cyc = 0;
    while (spi_cs_n !== 1'b0 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("[TB] FAIL start_cs_n: got %b expected 0 within 10 clk", spi_cs_n); end
    wait_hdr(0, 120, ok);
    checks++; if (!ok || cmd_rx !== EXP_CMD) begin errors++; $display("[TB] FAIL first_cmd: got %h (hdr %0b) expected %h", cmd_rx, ok, EXP_CMD); end
    checks++; if (!ok || addr_rx !== 24'h000000) begin errors++; $display("[TB] FAIL first_addr: got %h expected 000000", addr_rx); end
    wait_ready(120, ok);
    checks++; if (!ok || data !== 16'h1234) begin errors++; $display("[TB] FAIL first_word: got %h ready %0b expected 1234", data, ok); end
  endtask

  task automatic test_stall;
    bit bad;
    int cyc;
    repeat (45) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (spi_sck !== 1'b0 || spi_cs_n !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++; $display("[TB] FAIL stall_sck: sck %b cs_n %b expected sck 0 cs_n 0", spi_sck, spi_cs_n); end
    checks++; if (rcnt != HDR_BITS + 32) begin errors++; $display("[TB] FAIL stall_bits: got %0d expected %0d", rcnt, HDR_BITS + 32); end
    checks++; if (data_ready !== 1'b1 || data !== 16'h1234) begin errors++; $display("[TB] FAIL stall_head: got %h ready %b expected 1234", data, data_ready); end
    do_pop();
    checks++; if (data_ready !== 1'b1 || data !== 16'h5678) begin errors++; $display("[TB] FAIL second_word: got %h ready %b expected 5678", data, data_ready); end
    do_pop();
    cyc = 0;
    while (!data_ready && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (!data_ready || cyc > 32 || data !== flash_word(24'h4)) begin errors++; $display("[TB] FAIL third_word: got %h after %0d clk expected %h within 32", data, cyc, flash_word(24'h4)); end
    do_pop();
  endtask

  task automatic test_save_load;
    bit ok;
    int prev;
    save_addr = 1'b1;
    @(negedge clk);
    save_addr = 1'b0;
    saved_exp = exp_addr;
    for (int i = 0; i < 5; i++) begin
      wait_ready(80, ok);
      checks++; if (!ok || data !== flash_word(exp_addr)) begin errors++; $display("[TB] FAIL stream_word: got %h ready %0b expected %h", data, ok, flash_word(exp_addr)); end
      if (ok) do_pop();
    end
    prev = hdr_count;
    load_addr = 1'b1;
    @(negedge clk);
    load_addr = 1'b0;
    exp_addr = saved_exp;
    checks++; if (spi_cs_n !== 1'b1 || data_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_flush: cs_n %b ready %b expected cs_n 1 ready 0", spi_cs_n, data_ready); end
    wait_hdr(prev, 120, ok);
    checks++; if (!ok || addr_rx !== 24'h000006 || cmd_rx !== EXP_CMD) begin errors++; $display("[TB] FAIL load_addr: got %h cmd %h expected 000006 cmd %h", addr_rx, cmd_rx, EXP_CMD); end
    wait_ready(80, ok);
    checks++; if (!ok || data !== flash_word(24'h6)) begin errors++; $display("[TB] FAIL load_word: got %h expected %h", data, flash_word(24'h6)); end
  endtask

  task automatic test_stop;
    bit ok;
    bit bad;
    int prev;
    int hi;
    repeat (12) @(negedge clk);
    prev = hdr_count;
    stop_data = 1'b1;
    @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL stop_cs_n: cs_n %b sck %b expected 1 0", spi_cs_n, spi_sck); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL stop_ready: got %b expected 0", data_ready); end
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("[TB] FAIL stop_hold: cs_n went low while stop_data high, expected 1"); end
    stop_data = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1) break;
      hi++;
    end
    checks++; if (hi < 2 || hi >= 20) begin errors++; $display("[TB] FAIL stop_cs_high: cs_n high %0d clk after release expected 2..19", hi); end
    wait_hdr(prev, 120, ok);
    checks++; if (!ok || addr_rx !== exp_addr) begin errors++; $display("[TB] FAIL stop_restart_addr: got %h expected %h", addr_rx, exp_addr); end
    wait_ready(80, ok);
    checks++; if (!ok || data !== flash_word(exp_addr)) begin errors++; $display("[TB] FAIL stop_restart_word: got %h expected %h", data, flash_word(exp_addr)); end
  endtask

  task automatic test_clear_priority;
    bit ok;
    int prev;
    for (int i = 0; i < 40 && exp_addr != 24'h40; i++) begin
      wait_ready(80, ok);
      checks++; if (!ok || data !== flash_word(exp_addr)) begin errors++; $display("[TB] FAIL walk_word: got %h ready %0b expected %h", data, ok, flash_word(exp_addr)); end
      if (ok) do_pop();
      else break;
    end
    save_addr = 1'b1;
    @(negedge clk);
    save_addr = 1'b0;
    saved_exp = exp_addr;
    for (int i = 0; i < 2; i++) begin
      wait_ready(80, ok);
      checks++; if (!ok || data !== flash_word(exp_addr)) begin errors++; $display("[TB] FAIL post_save_word: got %h expected %h", data, flash_word(exp_addr)); end
      if (ok) do_pop();
    end
    prev = hdr_count;
    clear_addr = 1'b1;
    load_addr  = 1'b1;
    @(negedge clk);
    clear_addr = 1'b0;
    load_addr  = 1'b0;
    exp_addr   = 24'h0;
    wait_hdr(prev, 120, ok);
    checks++; if (!ok || addr_rx !== 24'h000000) begin errors++; $display("[TB] FAIL clear_wins_addr: got %h expected 000000", addr_rx); end
    wait_ready(80, ok);
    checks++; if (!ok || data !== 16'h1234) begin errors++; $display("[TB] FAIL clear_wins_word: got %h expected 1234", data); end
    prev = hdr_count;
    load_addr = 1'b1;
    @(negedge clk);
    load_addr = 1'b0;
    exp_addr  = saved_exp;
    wait_hdr(prev, 120, ok);
    checks++; if (!ok || addr_rx !== 24'h000040) begin errors++; $display("[TB] FAIL saved_kept_addr: got %h expected 000040", addr_rx); end
    wait_ready(80, ok);
    checks++; if (!ok || data !== flash_word(24'h40)) begin errors++; $display("[TB] FAIL saved_kept_word: got %h expected %h", data, flash_word(24'h40)); end
  endtask

  task automatic test_save_with_pop;
    bit ok;
    int prev;
    save_addr = 1'b1;
    read_next = 1'b1;
    @(negedge clk);
    save_addr = 1'b0;
    read_next = 1'b0;
    exp_addr  = exp_addr + 24'd2;
    saved_exp = exp_addr;
    wait_ready(80, ok);
    checks++; if (!ok || data !== flash_word(exp_addr)) begin errors++; $display("[TB] FAIL save_pop_word: got %h expected %h", data, flash_word(exp_addr)); end
    if (ok) do_pop();
    prev = hdr_count;
    load_addr = 1'b1;
    @(negedge clk);
    load_addr = 1'b0;
    exp_addr  = saved_exp;
    wait_hdr(prev, 120, ok);
    checks++; if (!ok || addr_rx !== 24'h000042) begin errors++; $display("[TB] FAIL save_pop_addr: got %h expected 000042", addr_rx); end
    wait_ready(80, ok);
    checks++; if (!ok || data !== flash_word(24'h42)) begin errors++; $display("[TB] FAIL save_pop_reload: got %h expected %h", data, flash_word(24'h42)); end
  endtask

  task automatic test_reset_midstream;
    bit ok;
    int prev;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL midreset_spi: cs_n %b sck %b expected 1 0", spi_cs_n, spi_sck); end
    checks++; if (data_ready !== 1'b0 || data !== 16'h0) begin errors++; $display("[TB] FAIL midreset_fifo: ready %b data %h expected 0 0000", data_ready, data); end
    @(negedge clk);
    prev = hdr_count;
    rst = 1'b0;
    exp_addr = 24'h0;
    wait_hdr(prev, 120, ok);
    checks++; if (!ok || addr_rx !== 24'h000000) begin errors++; $display("[TB] FAIL midreset_addr: got %h expected 000000", addr_rx); end
    wait_ready(80, ok);
    checks++; if (!ok || data !== 16'h1234) begin errors++; $display("[TB] FAIL midreset_word: got %h expected 1234", data); end
    checks++; if (dummy_err != 0) begin errors++; $display("[TB] FAIL dummy_mosi: %0d dummy bits high expected 0", dummy_err); end
  endtask

  initial begin
    test_reset();
    test_first_words();
    test_stall();
    test_save_load();
    test_stop();
    test_clear_priority();
    test_save_with_pop();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
